// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// fir_pkg : shared defaults and coefficient reset values for the FIR filter
// Revision: 1.0
// ============================================================================
package fir_pkg;

    localparam int FIR_DATA_W_DEF = 16;
    localparam int FIR_NTAPS_DEF  = 4;
    localparam int FIR_COEF_W_DEF = 8;

    // Reset value of coefficient k is k+1, clipped to the largest COEF_W value.
    function automatic int unsigned coef_reset_val(input int k, input int coef_w);
        longint unsigned max_v;
        longint unsigned val;
        max_v = (longint'(1) << coef_w) - 1;
        val   = longint'(k) + 1;
        return (val > max_v) ? int'(max_v) : int'(val);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_mac.sv
`default_nettype none
// ============================================================================
// fir_tap_mac : one tap's registered multiply (S1 product register)
// Revision: 1.0
// ============================================================================
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W_DEF,
    parameter int COEF_W = FIR_COEF_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [DATA_W-1:0]          x_i,
    input  logic [COEF_W-1:0]          c_i,
    output logic [DATA_W+COEF_W-1:0]   prod_o
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic [PROD_W-1:0] prod_q;
    logic [PROD_W-1:0] prod_d;

    assign prod_d = PROD_W'(x_i) * PROD_W'(c_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en_i) begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule
`default_nettype wire

// File: rtl/fir_stream_filter.sv
`default_nettype none
// ============================================================================
// fir_stream_filter : streaming unsigned FIR, 2-stage pipeline, valid/ready
// Revision: 1.0
// ============================================================================
module fir_stream_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W_DEF,
    parameter int NTAPS  = FIR_NTAPS_DEF,
    parameter int COEF_W = FIR_COEF_W_DEF,
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(NTAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]         coef_wdata,
    input  logic                      clear
);

    localparam int ADDR_W = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    logic [NTAPS-1:0][DATA_W-1:0] x_q;
    logic [NTAPS-1:0][DATA_W-1:0] x_d;
    logic [NTAPS-1:0][COEF_W-1:0] c_q;
    logic [NTAPS-1:0][PROD_W-1:0] prod_q;
    logic                         s1_valid_q;
    logic                         out_valid_q;
    logic [OUT_W-1:0]             out_data_q;
    logic [OUT_W-1:0]             sum_d;
    logic                         advance;
    logic                         accept;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance && !rst;
    assign accept   = in_valid && in_ready;

    // Products are formed from the post-shift delay line so S1 sees the new sample.
    always_comb begin
        x_d = x_q;
        if (clear) begin
            x_d = '0;
            if (accept) begin
                x_d[0] = in_data;
            end
        end else if (accept) begin
            x_d[0] = in_data;
            for (int k = 1; k < NTAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                c_q[k] <= COEF_W'(coef_reset_val(k, COEF_W));
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                if (coef_we && coef_addr == ADDR_W'(k)) begin
                    c_q[k] <= coef_wdata;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_tap
            fir_tap_mac #(
                .DATA_W (DATA_W),
                .COEF_W (COEF_W)
            ) u_mac (
                .clk    (clk),
                .rst    (rst),
                .en_i   (advance),
                .x_i    (x_d[k]),
                .c_i    (c_q[k]),
                .prod_o (prod_q[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= accept;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_d = sum_d + OUT_W'(prod_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            out_data_q  <= sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_stream_filter.sv
`default_nettype none
// ============================================================================
// tb_fir_stream_filter : directed self-checking bench for fir_stream_filter
// Revision: 1.0
// ============================================================================
module tb_fir_stream_filter;

    localparam int DATA_W = 16;
    localparam int NTAPS  = 4;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 26;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              coef_we;
    logic [1:0]        coef_addr;
    logic [COEF_W-1:0] coef_wdata;
    logic              clear;

    int n_tests = 0;
    int n_fail  = 0;

    logic             mon_en = 1'b0;
    logic [OUT_W-1:0] q_out[$];

    fir_stream_filter #(
        .DATA_W (DATA_W),
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .clear      (clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            q_out.push_back(out_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Unit impulse through the default coefficients 1,2,3,4.
    task automatic impulse(input string pfx);
        in_valid = 1'b1;
        in_data  = 16'd1;
        cyc();
        chk({pfx, "_lat_ov"}, 32'(out_valid), 32'd0);
        in_data = 16'd0;
        cyc();
        chk({pfx, "_y0_ov"}, 32'(out_valid), 32'd1);
        chk({pfx, "_y0"}, 32'(out_data), 32'd1);
        cyc();
        chk({pfx, "_y1"}, 32'(out_data), 32'd2);
        cyc();
        chk({pfx, "_y2"}, 32'(out_data), 32'd3);
        cyc();
        chk({pfx, "_y3"}, 32'(out_data), 32'd4);
        in_valid = 1'b0;
        cyc();
        chk({pfx, "_y4_ov"}, 32'(out_valid), 32'd1);
        chk({pfx, "_y4"}, 32'(out_data), 32'd0);
        cyc();
        chk({pfx, "_idle_ov"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int        exp_bp [8] = '{1, 4, 10, 20, 30, 40, 50, 60};
        int        idx;
        logic      acc;

        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        clear      = 1'b0;

        cyc();
        cyc();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        cyc();
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        impulse("imp");

        // Full-scale input
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        cyc();
        cyc();
        chk("max_y0", 32'(out_data), 32'd65535);
        cyc();
        chk("max_y1", 32'(out_data), 32'd196605);
        cyc();
        chk("max_y2", 32'(out_data), 32'd393210);
        in_valid = 1'b0;
        cyc();
        chk("max_y3", 32'(out_data), 32'd655350);
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // Backpressure: stream 1..8 with out_ready low for 3 cycles
        q_out.delete();
        mon_en = 1'b1;
        idx    = 1;
        for (int cnt = 0; cnt < 40 && q_out.size() < 8; cnt++) begin
            in_valid  = (idx <= 8);
            in_data   = 16'(idx);
            out_ready = !(cnt >= 4 && cnt <= 6);
            #1;
            if (!out_ready) begin
                chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mon_en    = 1'b0;
        chk("bp_count", 32'(q_out.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < q_out.size()) begin
                chk($sformatf("bp_y%0d", i), 32'(q_out[i]), 32'(exp_bp[i]));
            end
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;

        // Coefficient write in the accept cycle of sample A
        in_valid   = 1'b1;
        in_data    = 16'd2;
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd10;
        cyc();
        coef_we = 1'b0;
        in_data = 16'd3;
        cyc();
        in_valid = 1'b0;
        chk("coef_old", 32'(out_data), 32'd2);
        cyc();
        chk("coef_new", 32'(out_data), 32'd34);
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 8'd1;
        cyc();
        coef_we = 1'b0;
        clear   = 1'b1;
        cyc();
        clear = 1'b0;

        // Clear with a sample in the same cycle, plus a coefficient write
        in_valid = 1'b1;
        in_data  = 16'd5;
        cyc();
        cyc();
        chk("clr_y0", 32'(out_data), 32'd5);
        cyc();
        chk("clr_y1", 32'(out_data), 32'd15);
        in_data    = 16'd7;
        clear      = 1'b1;
        coef_we    = 1'b1;
        coef_addr  = 2'd1;
        coef_wdata = 8'd5;
        cyc();
        chk("clr_inflight", 32'(out_data), 32'd30);
        clear   = 1'b0;
        coef_we = 1'b0;
        in_data = 16'd1;
        cyc();
        chk("clr_sample", 32'(out_data), 32'd7);
        in_valid = 1'b0;
        cyc();
        chk("clr_after", 32'(out_data), 32'd36);
        cyc();
        chk("clr_idle_ov", 32'(out_valid), 32'd0);

        // Reset with two samples in flight
        in_valid = 1'b1;
        in_data  = 16'd9;
        cyc();
        cyc();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("mid_rst_ov", 32'(out_valid), 32'd0);
        chk("mid_rst_od", 32'(out_data), 32'd0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_ov2", 32'(out_valid), 32'd0);
        #1;
        chk("mid_rst_in_ready2", 32'(in_ready), 32'd1);
        cyc();
        chk("mid_rst_ov3", 32'(out_valid), 32'd0);

        impulse("imp2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fir_stream_filter.md
FIR_STREAM_FILTER -- requirements
Module: fir_stream_filter

Interface
REQ-001 Parameter DATA_W, default 16, unsigned sample width.
REQ-002 Parameter NTAPS, default 4, tap count, legal range 2..16.
REQ-003 Parameter COEF_W, default 8, unsigned coefficient width.
REQ-004 Parameter OUT_W, default DATA_W+COEF_W+$clog2(NTAPS), result width; it SHALL never truncate.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_data  in  DATA_W  input sample.
REQ-008 in_valid  in  1  in_data is valid.
REQ-009 in_ready  out  1  block accepts a sample this cycle.
REQ-010 out_data  out  OUT_W  filtered result.
REQ-011 out_valid  out  1  out_data is valid.
REQ-012 out_ready  in  1  downstream accepts out_data.
REQ-013 coef_we  in  1  coefficient write strobe.
REQ-014 coef_addr  in  $clog2(NTAPS)  coefficient index.
REQ-015 coef_wdata  in  COEF_W  coefficient value.
REQ-016 clear  in  1  zero the delay line without touching coefficients.

Function
REQ-017 A transfer SHALL occur on a cycle with valid and ready both high, on each port.
REQ-018 The delay line SHALL be x[0..NTAPS-1]; on input transfer, x[0] takes in_data and x[k] takes x[k-1].
REQ-019 Result for the accepted sample SHALL be y = sum over k of c[k]*x[k], using the delay line after the shift, unsigned, full precision.
REQ-020 The pipeline SHALL have 2 stages: S1 registers the NTAPS products; S2 registers the sum into out_data.
REQ-021 Latency SHALL be: sample accepted in cycle N gives out_valid=1 in cycle N+2 when out_ready stays high.
REQ-022 The pipeline SHALL advance when the S2 register is empty or out_ready=1.
REQ-023 in_ready SHALL equal the advance condition; it SHALL NOT depend combinationally on in_valid.
REQ-024 Stages SHALL carry valid bits, so bubbles propagate without producing outputs.
REQ-025 With in_valid and out_ready held high, throughput SHALL be 1 sample/cycle.
REQ-026 Under stall (out_valid=1, out_ready=0), out_data, S1 and the delay line SHALL hold.
REQ-027 coef_we SHALL write c[coef_addr] at the clock edge. Samples accepted in the same cycle use the old value; later samples use the new value.
REQ-028 Products already in S1 SHALL NOT be recomputed after a coefficient write.
REQ-029 clear SHALL zero x[] at the edge; in-flight S1/S2 results SHALL still drain.
REQ-030 A sample accepted in the clear cycle SHALL be loaded into x[0], with all other taps zero.
REQ-031 coef_we together with clear SHALL perform both operations.

Reset
REQ-032 rst SHALL force out_valid=0 and out_data=0, and clear the S1 valid bit.
REQ-033 rst SHALL zero x[], and set c[k]=k+1 (saturated to COEF_W).
REQ-034 in_ready SHALL be 0 during the rst cycle and 1 on the first cycle after rst.
REQ-035 rst mid-stream SHALL discard in-flight results; no out_valid SHALL appear for samples accepted before rst.

Structure
REQ-036 A shared package fir_pkg SHALL hold the default parameter values and the coefficient-reset function c(k)=k+1.
REQ-037 One sub-module, fir_tap_mac, SHALL provide one tap's registered multiply, generated NTAPS times; the adder tree stays in the top level.

Verification
REQ-038 Impulse: reset defaults; inputs 1,0,0,0,0 with out_ready=1 -> outputs 1,2,3,4,0, with the first at accept cycle+2.
REQ-039 Max value: four samples of 65535 -> fourth output 655350; no overflow at OUT_W=26.
REQ-040 Backpressure: out_ready low for 3 cycles during a stream of 1..8 -> in_ready low while stalled; no output lost or duplicated; sequence matches the golden model.
REQ-041 Coefficient update: write c[0]=10 in the accept cycle of sample A -> A uses c[0]=1; the next sample uses c[0]=10.
REQ-042 Clear: stream 5,5,5, then clear with sample 7 -> that output is 7 (c[0]=1); in-flight outputs are unaffected.
REQ-043 Reset mid-stream: rst asserted with 2 samples in flight -> no out_valid for them; after release, impulse test REQ-038 passes.
